mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 43 ++++
 rtl/mem_arbiter.sv | 103 ++++++++++
 tb/tb_mem_arbiter.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Two-master shared-memory bus bundle.
// The slave modport is the arbiter side; the master modport is the requester/memory side.
interface mem_arbiter_if #(
    parameter int W = 32
);
    logic         m0_req;
    logic         m0_we;
    logic [W-1:0] m0_adr;
    logic [W-1:0] m0_wdata;
    logic         m0_gnt;
    logic         m0_rvalid;
    logic [W-1:0] m0_rdata;
    logic         m1_req;
    logic         m1_we;
    logic [W-1:0] m1_adr;
    logic [W-1:0] m1_wdata;
    logic         m1_gnt;
    logic         m1_rvalid;
    logic [W-1:0] m1_rdata;
    logic [W-1:0] adr;
    logic [W-1:0] writedata;
    logic         memwrite;
    logic [W-1:0] readdata;
    logic         busy;

    modport slave (
        input  m0_req, m0_we, m0_adr, m0_wdata,
        input  m1_req, m1_we, m1_adr, m1_wdata,
        input  readdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output adr, writedata, memwrite, busy
    );

    modport master (
        output m0_req, m0_we, m0_adr, m0_wdata,
        output m1_req, m1_we, m1_adr, m1_wdata,
        output readdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  adr, writedata, memwrite, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port shared memory arbiter: IDLE -> ACCESS -> RESP, one transaction at a time.
// Round-robin or fixed-priority selection when both ports request together.
module mem_arbiter #(
    parameter int RR = 1,
    parameter int W  = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e       state_q, state_d;
    logic         owner_q, owner_d;
    logic         last_q, last_d;
    logic         we_q, we_d;
    logic [W-1:0] adr_q, adr_d;
    logic [W-1:0] wdata_q, wdata_d;
    logic         any_req;
    logic         win;
    logic         grant;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            we_q    <= 1'b0;
            adr_q   <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        any_req = bus.m0_req | bus.m1_req;
        if (bus.m0_req && bus.m1_req)
            win = (RR != 0) ? ~last_q : 1'b0;
        else
            win = bus.m1_req;
        // gnt is combinational, so it must also be masked while reset is held
        grant = (state_q == IDLE) && any_req && reset;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        we_d    = we_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ACCESS;
                    owner_d = win;
                    last_d  = win;
                    we_d    = win ? bus.m1_we : bus.m0_we;
                    adr_d   = win ? bus.m1_adr : bus.m0_adr;
                    wdata_d = win ? bus.m1_wdata : bus.m0_wdata;
                end
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.m0_gnt    = grant && !win;
        bus.m1_gnt    = grant && win;
        bus.m0_rvalid = 1'b0;
        bus.m1_rvalid = 1'b0;
        bus.m0_rdata  = '0;
        bus.m1_rdata  = '0;
        bus.adr       = '0;
        bus.writedata = '0;
        bus.memwrite  = 1'b0;
        bus.busy      = (state_q != IDLE);
        if (state_q == ACCESS) begin
            bus.adr       = adr_q;
            bus.writedata = wdata_q;
            bus.memwrite  = we_q;
        end
        if (state_q == RESP) begin
            bus.adr       = adr_q;
            bus.writedata = wdata_q;
            if (owner_q) begin
                bus.m1_rvalid = 1'b1;
                bus.m1_rdata  = we_q ? '0 : bus.readdata;
            end else begin
                bus.m0_rvalid = 1'b1;
                bus.m0_rdata  = we_q ? '0 : bus.readdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus reset-abort and idle sequences.
// A round-robin and a fixed-priority instance see identical stimulus.
module tb_mem_arbiter;
    logic clk;
    logic reset;
    int   vecs;
    int   errs;

    mem_arbiter_if #(.W(32)) b ();
    mem_arbiter_if #(.W(32)) bf ();

    mem_arbiter #(.RR(1), .W(32)) dut_rr (.clk(clk), .reset(reset), .bus(b));
    mem_arbiter #(.RR(0), .W(32)) dut_fp (.clk(clk), .reset(reset), .bus(bf));

    assign bf.m0_req   = b.m0_req;
    assign bf.m0_we    = b.m0_we;
    assign bf.m0_adr   = b.m0_adr;
    assign bf.m0_wdata = b.m0_wdata;
    assign bf.m1_req   = b.m1_req;
    assign bf.m1_we    = b.m1_we;
    assign bf.m1_adr   = b.m1_adr;
    assign bf.m1_wdata = b.m1_wdata;
    assign bf.readdata = b.readdata;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r0, w0;
        logic [31:0] a0, d0;
        logic        r1, w1;
        logic [31:0] a1, d1;
        logic [31:0] rd;
        logic        g0, v0;
        logic [31:0] q0;
        logic        g1, v1;
        logic [31:0] q1;
        logic [31:0] adr, wd;
        logic        mw, bz;
        logic        fg0, fg1;
    } vec_t;

    vec_t tbl[17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        b.m0_req   = v.r0;
        b.m0_we    = v.w0;
        b.m0_adr   = v.a0;
        b.m0_wdata = v.d0;
        b.m1_req   = v.r1;
        b.m1_we    = v.w1;
        b.m1_adr   = v.a1;
        b.m1_wdata = v.d1;
        b.readdata = v.rd;
    endtask

    task automatic check_all(input string t, input vec_t v);
        chk({t, " m0_gnt"}, 32'(b.m0_gnt), 32'(v.g0));
        chk({t, " m0_rvalid"}, 32'(b.m0_rvalid), 32'(v.v0));
        chk({t, " m0_rdata"}, b.m0_rdata, v.q0);
        chk({t, " m1_gnt"}, 32'(b.m1_gnt), 32'(v.g1));
        chk({t, " m1_rvalid"}, 32'(b.m1_rvalid), 32'(v.v1));
        chk({t, " m1_rdata"}, b.m1_rdata, v.q1);
        chk({t, " adr"}, b.adr, v.adr);
        chk({t, " writedata"}, b.writedata, v.wd);
        chk({t, " memwrite"}, 32'(b.memwrite), 32'(v.mw));
        chk({t, " busy"}, 32'(b.busy), 32'(v.bz));
        chk({t, " fp m0_gnt"}, 32'(bf.m0_gnt), 32'(v.fg0));
        chk({t, " fp m1_gnt"}, 32'(bf.m1_gnt), 32'(v.fg1));
    endtask

    function automatic vec_t mk(
        input logic r0, w0, input logic [31:0] a0, d0,
        input logic r1, w1, input logic [31:0] a1, d1,
        input logic [31:0] rd,
        input logic g0, v0, input logic [31:0] q0,
        input logic g1, v1, input logic [31:0] q1,
        input logic [31:0] adr, wd, input logic mw, bz,
        input logic fg0, fg1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
        v.rd = rd;
        v.g0 = g0; v.v0 = v0; v.q0 = q0;
        v.g1 = g1; v.v1 = v1; v.q1 = q1;
        v.adr = adr; v.wd = wd; v.mw = mw; v.bz = bz;
        v.fg0 = fg0; v.fg1 = fg1;
        return v;
    endfunction

    vec_t z;

    initial begin
        vecs = 0;
        errs = 0;
        z = mk(0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 0,0,0,0, 0,0);
        // port 0 read of 0x40; req dropped and address changed after gnt
        tbl[0]  = z;
        tbl[1]  = mk(1,0,32'h40,0, 0,0,0,0, 0, 1,0,0, 0,0,0, 0,0,0,0, 1,0);
        tbl[2]  = mk(0,0,32'hFF,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 32'h40,0,0,1, 0,0);
        tbl[3]  = mk(0,0,32'hFF,0, 0,0,0,0, 32'hDEADBEEF, 0,1,32'hDEADBEEF, 0,0,0,
                     32'h40,0,0,1, 0,0);
        // port 1 write
        tbl[4]  = mk(0,0,0,0, 1,1,32'h10,32'h12345678, 0, 0,0,0, 1,0,0, 0,0,0,0, 0,1);
        tbl[5]  = mk(0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 32'h10,32'h12345678,1,1, 0,0);
        tbl[6]  = mk(0,0,0,0, 0,0,0,0, 32'h55, 0,0,0, 0,1,0, 32'h10,32'h12345678,0,1, 0,0);
        tbl[7]  = z;
        // both held: RR alternates 0,1,0; fixed priority always port 0
        tbl[8]  = mk(1,0,32'h100,0, 1,0,32'h200,0, 0, 1,0,0, 0,0,0, 0,0,0,0, 1,0);
        tbl[9]  = mk(1,0,32'h100,0, 1,0,32'h200,0, 0, 0,0,0, 0,0,0, 32'h100,0,0,1, 0,0);
        tbl[10] = mk(1,0,32'h100,0, 1,0,32'h200,0, 32'hAAAA0000, 0,1,32'hAAAA0000, 0,0,0,
                     32'h100,0,0,1, 0,0);
        tbl[11] = mk(1,0,32'h100,0, 1,0,32'h200,0, 0, 0,0,0, 1,0,0, 0,0,0,0, 1,0);
        tbl[12] = mk(1,0,32'h100,0, 1,0,32'h200,0, 0, 0,0,0, 0,0,0, 32'h200,0,0,1, 0,0);
        tbl[13] = mk(1,0,32'h100,0, 1,0,32'h200,0, 32'hAAAA0000, 0,0,0, 0,1,32'hAAAA0000,
                     32'h200,0,0,1, 0,0);
        tbl[14] = mk(1,0,32'h100,0, 1,0,32'h200,0, 0, 1,0,0, 0,0,0, 0,0,0,0, 1,0);
        tbl[15] = mk(0,0,0,0, 0,0,0,0, 0, 0,0,0, 0,0,0, 32'h100,0,0,1, 0,0);
        tbl[16] = mk(0,0,0,0, 0,0,0,0, 32'h77, 0,1,32'h77, 0,0,0, 32'h100,0,0,1, 0,0);

        // reset held with requests pending: everything must read zero
        reset = 1'b0;
        drive(mk(1,1,32'h33,32'h44, 1,0,32'h55,0, 32'h66, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
        repeat (2) @(posedge clk);
        #5;
        check_all("reset", z);
        drive(z);
        @(posedge clk);
        #2 reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(posedge clk);
            #2 drive(tbl[i]);
            #3 check_all($sformatf("vec%0d", i), tbl[i]);
        end

        // reset during the ACCESS cycle of a write aborts it
        @(posedge clk);
        #2 drive(mk(0,0,0,0, 1,1,32'h20,32'h99, 0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
        #3 chk("abort m1_gnt", 32'(b.m1_gnt), 32'd1);
        @(posedge clk);
        #2 drive(z);
        #1 chk("abort memwrite pre", 32'(b.memwrite), 32'd1);
        chk("abort adr pre", b.adr, 32'h20);
        reset = 1'b0;
        #1 chk("abort memwrite", 32'(b.memwrite), 32'd0);
        chk("abort adr", b.adr, 32'h0);
        chk("abort busy", 32'(b.busy), 32'd0);
        @(posedge clk);
        #3 chk("abort m1_rvalid", 32'(b.m1_rvalid), 32'd0);
        chk("abort m0_rvalid", 32'(b.m0_rvalid), 32'd0);
        @(posedge clk);
        #2 reset = 1'b1;
        drive(mk(1,0,32'h8,0, 1,0,32'hC,0, 0, 0,0,0, 0,0,0, 0,0,0,0, 0,0));
        #3 chk("post reset rr m0_gnt", 32'(b.m0_gnt), 32'd1);
        chk("post reset rr m1_gnt", 32'(b.m1_gnt), 32'd0);
        chk("post reset fp m0_gnt", 32'(bf.m0_gnt), 32'd1);
        @(posedge clk);
        #2 drive(z);
        repeat (2) @(posedge clk);

        // quiet bus for ten cycles
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #5 check_all($sformatf("idle%0d", i), z);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
